fp_addsub_seq: RTL

Multi-cycle, parametrised floating-point adder/subtractor. It supersedes the single-cycle, equal-exponent-only adder in the FP datapath. Operands of any exponent difference are aligned and then normalised, one bit per cycle, under a start/done handshake. It sits between the operand registers and the result writeback, beside the other FP arithmetic units.

---
 rtl/fp_addsub_seq_if.sv | 32 +++
 rtl/fp_addsub_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_seq_if
// Brief    : Start/done handshake and operand/result bus of fp_addsub_seq.
// Revision : 1.0
// ============================================================================
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         add_start;
    logic         mode;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] add_result;
    logic         add_done;
    logic         add_overflow;
    logic         busy;

    modport master (
        output add_start, mode, op1, op2,
        input  add_result, add_done, add_overflow, busy
    );

    modport slave (
        input  add_start, mode, op1, op2,
        output add_result, add_done, add_overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_seq
// Brief    : Multi-cycle FP adder/subtractor; bit-serial align and normalise.
// Revision : 1.0
// ============================================================================
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire logic         clk,
    input  wire logic         n_rst,
    fp_addsub_seq_if.slave    bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 5;
    localparam int CNT_W = $clog2(MAN_W + 5);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAN_W + 4);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t           state, state_n;
    logic             sign_a, sign_a_n, sign_b, sign_b_n;
    logic             special, special_n, spec_sign, spec_sign_n;
    logic [EXP_W-1:0] exp_r, exp_r_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [MW-1:0]    m, m_n, mb, mb_n;
    logic [W-1:0]     result, result_n;
    logic             overflow, overflow_n, done, done_n;

    logic [EXP_W-1:0] exp1, exp2, exp_a, exp_b, exp_diff, exp_inc;
    logic [MAN_W-1:0] frac1, frac2;
    logic             sign2_eff, op1_big, inf1, inf2;
    logic [MW-1:0]    mant1, mant2;

    // Zero exponent flushes the fraction, so denormals decode as zero.
    assign exp1      = bus.op1[W-2:MAN_W];
    assign exp2      = bus.op2[W-2:MAN_W];
    assign frac1     = (exp1 == '0) ? '0 : bus.op1[MAN_W-1:0];
    assign frac2     = (exp2 == '0) ? '0 : bus.op2[MAN_W-1:0];
    assign sign2_eff = bus.op2[W-1] ^ bus.mode;
    assign inf1      = (exp1 == EXP_MAX);
    assign inf2      = (exp2 == EXP_MAX);
    assign mant1     = {1'b0, (exp1 != '0), frac1, 3'b000};
    assign mant2     = {1'b0, (exp2 != '0), frac2, 3'b000};
    assign op1_big   = ({exp1, frac1} >= {exp2, frac2});
    assign exp_a     = op1_big ? exp1 : exp2;
    assign exp_b     = op1_big ? exp2 : exp1;
    assign exp_diff  = exp_a - exp_b;
    assign exp_inc   = exp_r + EXP_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            special   <= 1'b0;
            spec_sign <= 1'b0;
            exp_r     <= '0;
            cnt       <= '0;
            m         <= '0;
            mb        <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sign_a    <= sign_a_n;
            sign_b    <= sign_b_n;
            special   <= special_n;
            spec_sign <= spec_sign_n;
            exp_r     <= exp_r_n;
            cnt       <= cnt_n;
            m         <= m_n;
            mb        <= mb_n;
            result    <= result_n;
            overflow  <= overflow_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        sign_a_n    = sign_a;
        sign_b_n    = sign_b;
        special_n   = special;
        spec_sign_n = spec_sign;
        exp_r_n     = exp_r;
        cnt_n       = cnt;
        m_n         = m;
        mb_n        = mb;
        result_n    = result;
        overflow_n  = overflow;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.add_start) begin
                    sign_a_n    = op1_big ? bus.op1[W-1] : sign2_eff;
                    sign_b_n    = op1_big ? sign2_eff : bus.op1[W-1];
                    exp_r_n     = exp_a;
                    m_n         = op1_big ? mant1 : mant2;
                    mb_n        = op1_big ? mant2 : mant1;
                    special_n   = inf1 | inf2;
                    spec_sign_n = inf1 ? bus.op1[W-1] : sign2_eff;
                    if (inf1 | inf2)
                        cnt_n = '0;
                    else if (32'(exp_diff) > 32'(MAN_W + 4))
                        cnt_n = CNT_MAX;
                    else
                        cnt_n = CNT_W'(exp_diff);
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt == '0) begin
                    state_n = ADD;
                end else begin
                    mb_n  = mb >> 1;
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ADD: begin
                // A has the larger magnitude, so the difference never goes negative.
                m_n     = (sign_a == sign_b) ? (m + mb) : (m - mb);
                state_n = NORM;
            end
            NORM: begin
                if (special) begin
                    result_n   = {spec_sign, EXP_MAX, {MAN_W{1'b0}}};
                    overflow_n = 1'b1;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end else if (m == '0) begin
                    result_n   = '0;
                    overflow_n = 1'b0;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end else if (m[MW-1]) begin
                    if (exp_inc == EXP_MAX) begin
                        result_n   = {sign_a, EXP_MAX, {MAN_W{1'b0}}};
                        overflow_n = 1'b1;
                    end else begin
                        result_n   = {sign_a, exp_inc, m[MW-2:4]};
                        overflow_n = 1'b0;
                    end
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (m[MW-2]) begin
                    result_n   = {sign_a, exp_r, m[MW-3:3]};
                    overflow_n = 1'b0;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end else if (exp_r == EXP_W'(1)) begin
                    result_n   = '0;
                    overflow_n = 1'b0;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end else begin
                    m_n     = m << 1;
                    exp_r_n = exp_r - EXP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.add_result   = result;
    assign bus.add_done     = done;
    assign bus.add_overflow = overflow;
    assign bus.busy         = (state != IDLE);
endmodule
`default_nettype wire
